// File: rtl/music_player.sv
// -----------------------------------------------------------------------------
// music_player
//   Melody sequencer and square-wave tone generator. Walks the 64-entry
//   registered melody ROM one address per beat. Latches the returned note
//   index and drives the piezo buzzer with a square wave of matching pitch.
//   Each beat ends with a short silent gap, so repeated notes are heard
//   as separate notes.
//
// Ports
//   clk      in   1  system clock, rising edge
//   rst_n    in   1  asynchronous active-low reset
//   start    in   1  pulse: begin playback from ROM address 0
//   stop     in   1  pulse: abort playback (wins over a simultaneous start)
//   pause    in   1  level: freeze beat/tone counters, buzzer silent
//   loop_en  in   1  level: wrap 63->0 instead of finishing
//   music    in   5  note index from the ROM, one clk behind cnt
//   cnt      out  6  ROM address of the current beat
//   beep     out  1  buzzer drive
//   playing  out  1  high while in PLAY (also while paused)
//   done     out  1  one-cycle pulse when the last beat ends without looping
// -----------------------------------------------------------------------------
module music_player #(
    parameter int CLK_HZ      = 50_000_000,
    parameter int BEAT_CYCLES = 12_500_000,
    parameter int GAP_CYCLES  = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       pause,
    input  logic       loop_en,
    input  logic [4:0] music,
    output logic [5:0] cnt,
    output logic       beep,
    output logic       playing,
    output logic       done
);

    localparam int BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
    // Sized for the lowest note (262 Hz), which has the longest half-period.
    localparam int TW = $clog2(CLK_HZ / (2 * 262) + 1);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
    // Last beat position at which the tone is still audible.
    localparam logic [BW-1:0] GATE_LAST = BW'(BEAT_CYCLES - GAP_CYCLES - 1);
    localparam logic [5:0]    LAST_ADDR = 6'd63;

    typedef enum logic {
        IDLE,
        PLAY
    } state_t;

    state_t        state;
    logic [BW-1:0] beat_cnt;
    logic [TW-1:0] tone_cnt;
    logic [TW-1:0] half_per;

    // Note index to half-period lookup. Each entry is a constant expression
    // of CLK_HZ, so the table folds to constants at elaboration.
    // Index 0 and 22..31 are rests.
    function automatic logic [TW-1:0] half_period(input logic [4:0] idx);
        logic [TW-1:0] hp;
        case (idx)
            5'd1:    hp = TW'(CLK_HZ / (2 * 262));
            5'd2:    hp = TW'(CLK_HZ / (2 * 294));
            5'd3:    hp = TW'(CLK_HZ / (2 * 330));
            5'd4:    hp = TW'(CLK_HZ / (2 * 349));
            5'd5:    hp = TW'(CLK_HZ / (2 * 392));
            5'd6:    hp = TW'(CLK_HZ / (2 * 440));
            5'd7:    hp = TW'(CLK_HZ / (2 * 494));
            5'd8:    hp = TW'(CLK_HZ / (2 * 523));
            5'd9:    hp = TW'(CLK_HZ / (2 * 587));
            5'd10:   hp = TW'(CLK_HZ / (2 * 659));
            5'd11:   hp = TW'(CLK_HZ / (2 * 698));
            5'd12:   hp = TW'(CLK_HZ / (2 * 784));
            5'd13:   hp = TW'(CLK_HZ / (2 * 880));
            5'd14:   hp = TW'(CLK_HZ / (2 * 988));
            5'd15:   hp = TW'(CLK_HZ / (2 * 1047));
            5'd16:   hp = TW'(CLK_HZ / (2 * 1175));
            5'd17:   hp = TW'(CLK_HZ / (2 * 1319));
            5'd18:   hp = TW'(CLK_HZ / (2 * 1397));
            5'd19:   hp = TW'(CLK_HZ / (2 * 1568));
            5'd20:   hp = TW'(CLK_HZ / (2 * 1760));
            5'd21:   hp = TW'(CLK_HZ / (2 * 1976));
            default: hp = '0;
        endcase
        return hp;
    endfunction

    // Sequencer FSM plus tone generator. All outputs are registered.
    // The tone gate is evaluated on the beat position the counter is about
    // to take, so a registered beep is 0 exactly when the registered
    // beat_cnt is outside the audible window.
    // The note is latched on the edge where beat_cnt==1: cnt moved at beat
    // position 0 and the registered ROM needs one more edge before music
    // is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            beat_cnt <= '0;
            tone_cnt <= '0;
            half_per <= '0;
            beep     <= 1'b0;
            playing  <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    beep     <= 1'b0;
                    tone_cnt <= '0;
                    if (start && !stop) begin
                        state    <= PLAY;
                        playing  <= 1'b1;
                        cnt      <= '0;
                        beat_cnt <= '0;
                    end
                end

                PLAY: begin
                    if (stop) begin
                        state    <= IDLE;
                        playing  <= 1'b0;
                        beep     <= 1'b0;
                        tone_cnt <= '0;
                        beat_cnt <= '0;
                    end else if (pause) begin
                        beep <= 1'b0;
                    end else if (beat_cnt == BEAT_LAST) begin
                        beat_cnt <= '0;
                        beep     <= 1'b0;
                        tone_cnt <= '0;
                        if (cnt != LAST_ADDR) begin
                            cnt <= cnt + 6'd1;
                        end else if (loop_en) begin
                            cnt <= '0;
                        end else begin
                            state   <= IDLE;
                            playing <= 1'b0;
                            done    <= 1'b1;
                        end
                    end else begin
                        beat_cnt <= beat_cnt + BW'(1);
                        if (beat_cnt == BW'(1)) begin
                            half_per <= half_period(music);
                            tone_cnt <= '0;
                            beep     <= 1'b0;
                        end else if (beat_cnt >= BW'(2) && beat_cnt < GATE_LAST &&
                                     half_per != '0) begin
                            if (tone_cnt == half_per - TW'(1)) begin
                                tone_cnt <= '0;
                                beep     <= ~beep;
                            end else begin
                                tone_cnt <= tone_cnt + TW'(1);
                            end
                        end else begin
                            tone_cnt <= '0;
                            beep     <= 1'b0;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    playing <= 1'b0;
                    beep    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_music_player.sv
// -----------------------------------------------------------------------------
// tb_music_player
//   Directed self-checking bench for music_player. The main instance uses
//   1 MHz / 4000-cycle beats / 400-cycle gap. A second instance with 8-cycle
//   beats covers the end-of-melody behaviour (done, hold at 63, wrap) in a
//   short run. Both read a registered 64-entry ROM model.
// -----------------------------------------------------------------------------
module tb_music_player;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, stop, pause, loop_en;
    logic [4:0] music;
    logic [5:0] cnt;
    logic       beep, playing, done;

    logic       start_s, stop_s, pause_s, loop_s;
    logic [4:0] music_s;
    logic [5:0] cnt_s;
    logic       beep_s, playing_s, done_s;

    logic [4:0] rom [64];

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    int   high_cnt, rises, first_rise, bad_runs, gap_beep, cnt_bad, run_len;
    int   pause_beep, play_bad, resume_high, done_cnt, done_at;
    logic prev_beep;

    music_player #(
        .CLK_HZ     (1_000_000),
        .BEAT_CYCLES(4000),
        .GAP_CYCLES (400)
    ) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .stop   (stop),
        .pause  (pause),
        .loop_en(loop_en),
        .music  (music),
        .cnt    (cnt),
        .beep   (beep),
        .playing(playing),
        .done   (done)
    );

    music_player #(
        .CLK_HZ     (1_000_000),
        .BEAT_CYCLES(8),
        .GAP_CYCLES (2)
    ) u_short (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_s),
        .stop   (stop_s),
        .pause  (pause_s),
        .loop_en(loop_s),
        .music  (music_s),
        .cnt    (cnt_s),
        .beep   (beep_s),
        .playing(playing_s),
        .done   (done_s)
    );

    // 100 MHz simulation clock; only cycle counts matter.
    always #5 clk = ~clk;

    // Registered ROM model: data follows the address by one clock.
    always @(posedge clk) begin
        music   <= rom[cnt];
        music_s <= rom[cnt_s];
    end

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic s, input logic p, input logic t);
        start = s;
        stop  = p;
        pause = t;
    endtask

    // Observe one beat of the main instance, one sample per clock.
    task automatic watchBeat(input int n, input logic [5:0] exp_cnt);
        high_cnt = 0; rises = 0; first_rise = -1; bad_runs = 0;
        gap_beep = 0; cnt_bad = 0; run_len = 0; prev_beep = 1'b0;
        for (int k = 0; k < n; k++) begin
            if (beep === 1'b1) begin
                high_cnt++;
                run_len++;
                if (prev_beep !== 1'b1) begin
                    rises++;
                    if (first_rise < 0) first_rise = k;
                end
            end else begin
                if (prev_beep === 1'b1 && run_len != 568) bad_runs++;
                run_len = 0;
            end
            if (beep !== 1'b0 && (k < 3 || k >= 3600)) gap_beep++;
            if (cnt !== exp_cnt) cnt_bad++;
            prev_beep = beep;
            tick(1);
        end
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 5'd7;
        rom[0] = 5'd13;   // 880 Hz  -> half period 568
        rom[1] = 5'd0;    // rest
        rom[2] = 5'd15;   // 1047 Hz -> half period 477
        rom[3] = 5'd13;

        rst_n   = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0);
        loop_en = 1'b0;
        start_s = 1'b0; stop_s = 1'b0; pause_s = 1'b0; loop_s = 1'b0;

        // Reset state
        tick(2);
        checkOutput("reset_cnt", 32'(cnt), 32'd0);
        checkOutput("reset_beep", 32'(beep), 32'd0);
        checkOutput("reset_playing", 32'(playing), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        tick(2);

        // Start: beat 0 plays 880 Hz
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("start_playing", 32'(playing), 32'd1);
        checkOutput("start_cnt", 32'(cnt), 32'd0);
        watchBeat(4000, 6'd0);
        checkOutput("b0_cnt_held", 32'(cnt_bad), 32'd0);
        checkOutput("b0_first_rise", 32'(first_rise), 32'd570);
        checkOutput("b0_rises", 32'(rises), 32'd3);
        checkOutput("b0_run_len", 32'(bad_runs), 32'd0);
        checkOutput("b0_high_total", 32'(high_cnt), 32'd1704);
        checkOutput("b0_gate", 32'(gap_beep), 32'd0);
        checkOutput("b0_cnt_next", 32'(cnt), 32'd1);

        // Beat 1: rest, silent for the whole beat
        watchBeat(4000, 6'd1);
        checkOutput("b1_silent", 32'(high_cnt), 32'd0);
        checkOutput("b1_cnt_held", 32'(cnt_bad), 32'd0);
        checkOutput("b1_cnt_next", 32'(cnt), 32'd2);
        checkOutput("b1_playing", 32'(playing), 32'd1);

        // Beat 2: pause for 1000 clks starting at beat position 1500
        pause_beep = 0; cnt_bad = 0; play_bad = 0; resume_high = 0;
        for (int t = 0; t < 5000; t++) begin
            if (t == 1500) checkOutput("b2_beep_before_pause", 32'(beep), 32'd1);
            if (t > 1500 && t <= 2500 && beep !== 1'b0) pause_beep++;
            if (t > 2500 && beep === 1'b1) resume_high++;
            if (cnt !== 6'd2) cnt_bad++;
            if (playing !== 1'b1) play_bad++;
            pause = (t >= 1500 && t < 2500);
            tick(1);
        end
        pause = 1'b0;
        checkOutput("pause_beep", 32'(pause_beep), 32'd0);
        checkOutput("pause_cnt_held", 32'(cnt_bad), 32'd0);
        checkOutput("pause_playing", 32'(play_bad), 32'd0);
        checkOutput("pause_resumed_tone", 32'(resume_high > 0), 32'd1);
        checkOutput("pause_cnt_next", 32'(cnt), 32'd3);

        // Asynchronous reset in the middle of a sounding note
        tick(600);
        checkOutput("pre_reset_beep", 32'(beep), 32'd1);
        checkOutput("pre_reset_cnt", 32'(cnt), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_cnt", 32'(cnt), 32'd0);
        checkOutput("async_reset_beep", 32'(beep), 32'd0);
        checkOutput("async_reset_playing", 32'(playing), 32'd0);
        tick(1);
        rst_n = 1'b1;
        tick(1);

        // Simultaneous stop and start in PLAY: stop wins
        applyStimulus(1'b1, 1'b0, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("restart_playing", 32'(playing), 32'd1);
        tick(10);
        applyStimulus(1'b1, 1'b1, 1'b0);
        tick(1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("stop_wins_playing", 32'(playing), 32'd0);
        tick(3);
        checkOutput("stop_stays_idle", 32'(playing), 32'd0);
        checkOutput("stop_no_done", 32'(done), 32'd0);

        // Short instance, loop off: run to the end of address 63
        loop_s  = 1'b0;
        start_s = 1'b1;
        tick(1);
        done_cnt = 0; done_at = -1;
        for (int t = 0; t < 520; t++) begin
            start_s = (t == 20);
            if (t == 24) checkOutput("start_ignored_cnt", 32'(cnt_s), 32'd3);
            if (done_s === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = t;
            end
            if (t == 511) begin
                checkOutput("last_beat_cnt", 32'(cnt_s), 32'd63);
                checkOutput("last_beat_playing", 32'(playing_s), 32'd1);
            end
            if (t == 512) checkOutput("end_playing", 32'(playing_s), 32'd0);
            tick(1);
        end
        checkOutput("done_pulses", 32'(done_cnt), 32'd1);
        checkOutput("done_time", 32'(done_at), 32'd512);
        checkOutput("end_cnt_hold", 32'(cnt_s), 32'd63);
        checkOutput("end_idle", 32'(playing_s), 32'd0);

        // Short instance, loop on: wrap 63 -> 0 and keep playing
        loop_s  = 1'b1;
        start_s = 1'b1;
        tick(1);
        start_s  = 1'b0;
        done_cnt = 0;
        for (int t = 0; t < 520; t++) begin
            if (done_s === 1'b1) done_cnt++;
            if (t == 512) begin
                checkOutput("wrap_cnt", 32'(cnt_s), 32'd0);
                checkOutput("wrap_playing", 32'(playing_s), 32'd1);
            end
            tick(1);
        end
        checkOutput("wrap_no_done", 32'(done_cnt), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
